// File: rtl/fault_result_writer_pkg.sv
// Shared definitions for the fault-map writer and its eNVM-side consumers:
// FSM state encoding, default fault thresholds and the threshold compare.
package fault_result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } frw_state_e;

  localparam int unsigned DEFAULT_ROW_FAULT_THRESHOLD = 2;
  localparam int unsigned DEFAULT_COL_FAULT_THRESHOLD = 2;

  // Unsigned compare: threshold 0 flags everything, threshold > N flags nothing.
  function automatic logic meets_threshold(input int unsigned count,
                                           input int unsigned thr);
    return count >= thr;
  endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of a WIDTH-bit vector.
module popcount_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  // Sum the individual bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + ($clog2(WIDTH+1))'(bits[i]);
    end
  end

endmodule

// File: rtl/fault_result_writer.sv
// Accumulates per-PE mismatch results into an N x N fault map and streams
// the map to eNVM one row per cycle with row/column fault verdicts.
module fault_result_writer
  import fault_result_writer_pkg::*;
#(
  parameter int          SYSTOLIC_SIZE       = 8,
  parameter int          ADDR_WIDTH          = $clog2(SYSTOLIC_SIZE),
  parameter int unsigned ROW_FAULT_THRESHOLD = DEFAULT_ROW_FAULT_THRESHOLD,
  parameter int unsigned COL_FAULT_THRESHOLD = DEFAULT_COL_FAULT_THRESHOLD,
  parameter int          COUNT_WIDTH         = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     result_valid,
  input  logic [ADDR_WIDTH-1:0]    result_row,
  input  logic [SYSTOLIC_SIZE-1:0] result_mismatch,
  input  logic                     flush_start,
  output logic                     busy,
  output logic                     done,
  output logic                     drop_err,
  output logic [COUNT_WIDTH-1:0]   fault_count,
  output logic                     detection_en,
  output logic [ADDR_WIDTH-1:0]    counter,
  output logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
  output logic                     row_fault_detection,
  output logic                     column_fault_detection
);

  localparam int PC_W = $clog2(SYSTOLIC_SIZE+1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE-1);

  frw_state_e               state;
  logic [SYSTOLIC_SIZE-1:0] fmap [SYSTOLIC_SIZE];
  logic [SYSTOLIC_SIZE-1:0] row_bits;
  logic [SYSTOLIC_SIZE-1:0] col_bits;
  logic [PC_W-1:0]          row_pc;
  logic [PC_W-1:0]          col_pc;
  logic [PC_W-1:0]          map_row_pc [SYSTOLIC_SIZE];
  logic                     row_in_range;

  // Rows beyond N-1 are only representable when N is not a power of two.
  assign row_in_range = (int'(result_row) < SYSTOLIC_SIZE);

  // Control FSM plus fault map: map only changes in IDLE, so it is frozen while streaming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      drop_err <= 1'b0;
      for (int i = 0; i < SYSTOLIC_SIZE; i++) fmap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (clear) begin
            // Clear wins over a coincident result, which is dropped silently.
            drop_err <= 1'b0;
            for (int i = 0; i < SYSTOLIC_SIZE; i++) fmap[i] <= '0;
          end else if (result_valid && row_in_range) begin
            fmap[result_row] <= fmap[result_row] | result_mismatch;
          end
          if (flush_start) state <= STREAM;
        end
        STREAM: begin
          if (result_valid) drop_err <= 1'b1;
          if (counter == LAST_ROW) begin
            state   <= DONE;
            counter <= '0;
          end else begin
            counter <= counter + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          if (result_valid) drop_err <= 1'b1;
          state   <= IDLE;
          counter <= '0;
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign detection_en = (state == STREAM);

  // Select the map row and column addressed by counter.
  always_comb begin
    row_bits = fmap[counter];
    col_bits = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) col_bits[i] = fmap[i][counter];
  end

  popcount_n #(.WIDTH(SYSTOLIC_SIZE)) u_row_pc (.bits(row_bits), .count(row_pc));
  popcount_n #(.WIDTH(SYSTOLIC_SIZE)) u_col_pc (.bits(col_bits), .count(col_pc));

  for (genvar g = 0; g < SYSTOLIC_SIZE; g++) begin : g_total
    popcount_n #(.WIDTH(SYSTOLIC_SIZE)) u_map_pc (.bits(fmap[g]), .count(map_row_pc[g]));
  end

  // Total faults as the sum of per-row counts.
  always_comb begin
    fault_count = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      fault_count = fault_count + COUNT_WIDTH'(map_row_pc[i]);
    end
  end

  assign single_pe_detection    = detection_en ? row_bits : '0;
  assign row_fault_detection    = detection_en && meets_threshold(32'(row_pc), ROW_FAULT_THRESHOLD);
  assign column_fault_detection = detection_en && meets_threshold(32'(col_pc), COL_FAULT_THRESHOLD);

endmodule

// File: tb/tb_fault_result_writer.sv
// Bench for fault_result_writer: directed scenarios plus randomized result
// streams, compared against a fault-map reference model held in the bench.
module tb_fault_result_writer;
  import fault_result_writer_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n, clear, result_valid, flush_start;
  logic [AW-1:0] result_row;
  logic [N-1:0]  result_mismatch;
  logic          busy, done, drop_err, detection_en;
  logic [CW-1:0] fault_count;
  logic [AW-1:0] counter;
  logic [N-1:0]  single_pe_detection;
  logic          row_fault_detection, column_fault_detection;

  logic [N-1:0] model [N];
  logic         model_drop;
  int           vecs = 0;
  int           errs = 0;

  always #5 clk = ~clk;

  fault_result_writer #(.SYSTOLIC_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .result_valid(result_valid),
    .result_row(result_row), .result_mismatch(result_mismatch),
    .flush_start(flush_start), .busy(busy), .done(done), .drop_err(drop_err),
    .fault_count(fault_count), .detection_en(detection_en), .counter(counter),
    .single_pe_detection(single_pe_detection),
    .row_fault_detection(row_fault_detection),
    .column_fault_detection(column_fault_detection)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int row_cnt(input int r);
    return $countones(model[r]);
  endfunction

  function automatic int col_cnt(input int c);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(model[i][c]);
    return n;
  endfunction

  function automatic int total_cnt();
    int n = 0;
    for (int i = 0; i < N; i++) n += row_cnt(i);
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = '0;
    model_drop = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] r, input logic [N-1:0] m, input logic clr);
    result_valid = 1'b1; result_row = r; result_mismatch = m; clear = clr;
    step();
    result_valid = 1'b0; clear = 1'b0;
    if (clr) model_clear();
    else model[r] = model[r] | m;
  endtask

  // Full flush with per-row checks; drop_at injects an illegal result (plus
  // ignored clear/flush_start) in that stream cycle.
  task automatic do_flush(input int drop_at, input logic with_res,
                          input logic [AW-1:0] r, input logic [N-1:0] m);
    flush_start = 1'b1;
    if (with_res) begin
      result_valid = 1'b1; result_row = r; result_mismatch = m;
    end
    step();
    flush_start = 1'b0; result_valid = 1'b0;
    if (with_res) model[r] = model[r] | m;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("det_en[%0d]", k), 64'(detection_en), 64'(1));
      chk($sformatf("counter[%0d]", k), 64'(counter), 64'(k));
      chk($sformatf("busy[%0d]", k), 64'(busy), 64'(1));
      chk($sformatf("done_early[%0d]", k), 64'(done), 64'(0));
      chk($sformatf("pe[%0d]", k), 64'(single_pe_detection), 64'(model[k]));
      chk($sformatf("row_fault[%0d]", k), 64'(row_fault_detection),
          64'(row_cnt(k) >= int'(DEFAULT_ROW_FAULT_THRESHOLD)));
      chk($sformatf("col_fault[%0d]", k), 64'(column_fault_detection),
          64'(col_cnt(k) >= int'(DEFAULT_COL_FAULT_THRESHOLD)));
      if (k == drop_at) begin
        result_valid = 1'b1; result_row = AW'($urandom); result_mismatch = N'($urandom) | 8'h01;
        clear = 1'b1; flush_start = 1'b1;
      end
      step();
      result_valid = 1'b0; clear = 1'b0; flush_start = 1'b0;
      if (k == drop_at) model_drop = 1'b1;
    end
    chk("done_pulse", 64'(done), 64'(1));
    chk("busy_done", 64'(busy), 64'(1));
    chk("det_en_done", 64'(detection_en), 64'(0));
    chk("counter_done", 64'(counter), 64'(0));
    chk("pe_done", 64'(single_pe_detection), 64'(0));
    step();
    chk("done_after", 64'(done), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
    chk("drop_err_after", 64'(drop_err), 64'(model_drop));
    chk("fault_count_after", 64'(fault_count), 64'(total_cnt()));
  endtask

  initial begin
    logic saw_done;
    rst_n = 1'b0; clear = 1'b0; result_valid = 1'b0; flush_start = 1'b0;
    result_row = '0; result_mismatch = '0;
    model_clear();

    // Reset state
    step(); step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_drop", 64'(drop_err), 64'(0));
    chk("rst_count", 64'(fault_count), 64'(0));
    chk("rst_det_en", 64'(detection_en), 64'(0));
    chk("rst_counter", 64'(counter), 64'(0));
    chk("rst_pe", 64'(single_pe_detection), 64'(0));
    chk("rst_rowf", 64'(row_fault_detection), 64'(0));
    chk("rst_colf", 64'(column_fault_detection), 64'(0));
    rst_n = 1'b1;
    step();

    // Empty-map flush
    do_flush(-1, 1'b0, '0, '0);

    // Row/column verdicts: row2=03, row5=01
    send(3'd2, 8'h03, 1'b0);
    send(3'd5, 8'h01, 1'b0);
    chk("count_3", 64'(fault_count), 64'(3));
    do_flush(-1, 1'b0, '0, '0);

    // OR accumulation on the same row
    send(3'd0, 8'h00, 1'b1);
    send(3'd3, 8'h01, 1'b0);
    send(3'd3, 8'h80, 1'b0);
    chk("count_2", 64'(fault_count), 64'(2));
    do_flush(-1, 1'b0, '0, '0);

    // Result in STREAM cycle 3 is dropped and drop_err sticks
    do_flush(3, 1'b0, '0, '0);
    step(); step();
    chk("drop_sticky", 64'(drop_err), 64'(1));
    chk("map_frozen", 64'(fault_count), 64'(total_cnt()));
    send(3'd0, 8'h00, 1'b1);
    chk("drop_cleared", 64'(drop_err), 64'(0));

    // Clear together with a result: clear wins, no drop_err
    send(3'd1, 8'h0F, 1'b0);
    send(3'd0, 8'hFF, 1'b1);
    chk("clear_wins_count", 64'(fault_count), 64'(0));
    chk("clear_wins_drop", 64'(drop_err), 64'(0));

    // Randomized sessions; last result rides along with flush_start
    for (int s = 0; s < 4; s++) begin
      send(3'd0, 8'h00, 1'b1);
      for (int j = 0; j < 6 + s * 3; j++)
        send(AW'($urandom), N'($urandom & $urandom & ($urandom | $urandom)), 1'b0);
      chk($sformatf("rand_count[%0d]", s), 64'(fault_count), 64'(total_cnt()));
      do_flush((s == 2) ? 6 : -1, 1'b1, AW'($urandom), N'($urandom & $urandom));
    end

    // Reset mid-stream aborts without a done pulse
    send(3'd0, 8'h00, 1'b1);
    send(3'd4, 8'h33, 1'b0);
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    repeat (4) step();
    chk("abort_counter", 64'(counter), 64'(4));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    chk("abort_det_en", 64'(detection_en), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_count", 64'(fault_count), 64'(0));
    saw_done = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      saw_done |= done;
      step();
    end
    chk("abort_no_done", 64'(saw_done), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
